uart_frame_rx: RTL and testbench

UART_FRAME_RX -- requirements
Module: uart_frame_rx

---
 rtl/uart_frame_rx.sv | 136 +++++++++++++
 tb/tb_uart_frame_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// UART receiver: 8 data bits LSB first, even parity bit, one stop bit.
// Samples each bit at mid-period using a bit timer started on the synchronized falling edge.
module uart_frame_rx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [8:0] frame,
    output logic       frame_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] FULL_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic [1:0]  sync_q;
    logic        rx_s;
    logic [2:0]  state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        par_q, par_d;
    logic [8:0]  frame_q, frame_d;
    logic        valid_q, valid_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;

    assign rx_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 16'd1;
        idx_d   = idx_q;
        data_d  = data_q;
        par_d   = par_q;
        frame_d = frame_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = 16'd0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (timer_q == HALF_LAST) begin
                    timer_d = 16'd0;
                    idx_d   = 3'd0;
                    // A start bit that has gone high by mid-period was a glitch.
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (timer_q == FULL_LAST) begin
                    timer_d       = 16'd0;
                    data_d[idx_q] = rx_s;
                    idx_d         = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (timer_q == FULL_LAST) begin
                    timer_d = 16'd0;
                    par_d   = rx_s;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (timer_q == FULL_LAST) begin
                    timer_d = 16'd0;
                    if (rx_s) begin
                        frame_d = {par_q, data_q};
                        valid_d = 1'b1;
                        perr_d  = ^{par_q, data_q};
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                // Hold off until the line recovers so a break gives one frame_err.
                timer_d = 16'd0;
                if (rx_s) state_d = S_IDLE;
            end
            default: begin
                timer_d = 16'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q  <= 2'b11;
            state_q <= S_IDLE;
            timer_q <= 16'd0;
            idx_q   <= 3'd0;
            data_q  <= 8'd0;
            par_q   <= 1'b0;
            frame_q <= 9'h000;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            par_q   <= par_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign frame       = frame_q;
    assign frame_valid = valid_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx at 16 clocks per bit; a negedge monitor counts output pulses.
module tb_uart_frame_rx;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [8:0] frame;
    logic       frame_valid, parity_err, frame_err, busy;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    int n_valid = 0, n_perr = 0, n_ferr = 0, n_perr_alone = 0, n_long = 0;
    int last_valid_cyc = 0;
    logic [8:0] frames_seen [8];
    logic prev_v = 1'b0, prev_p = 1'b0, prev_f = 1'b0;

    uart_frame_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .frame       (frame),
        .frame_valid (frame_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin
            frames_seen[n_valid % 8] = frame;
            n_valid        = n_valid + 1;
            last_valid_cyc = cyc;
        end
        if (parity_err) n_perr = n_perr + 1;
        if (frame_err) n_ferr = n_ferr + 1;
        if (parity_err && !frame_valid) n_perr_alone = n_perr_alone + 1;
        if ((frame_valid && prev_v) || (parity_err && prev_p) || (frame_err && prev_f))
            n_long = n_long + 1;
        prev_v = frame_valid;
        prev_p = parity_err;
        prev_f = frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests = n_tests + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clk(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(stop);
    endtask

    int b_valid, b_perr, b_ferr, start_cyc, lat;

    initial begin
        // Reset state
        wait_clk(3);
        check("rst_frame", 32'(frame), 32'h000);
        check("rst_pulses", 32'({frame_valid, parity_err, frame_err}), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        wait_clk(2 * CPB);

        // 0xA5, parity 0: clean frame, plus latency from the falling edge
        b_valid = n_valid; b_perr = n_perr; b_ferr = n_ferr;
        start_cyc = cyc;
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_clk(2 * CPB);
        check("a5_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        check("a5_frame", 32'(frame), 32'h0A5);
        check("a5_perr", 32'(n_perr - b_perr), 32'd0);
        check("a5_ferr", 32'(n_ferr - b_ferr), 32'd0);
        lat = last_valid_cyc - start_cyc;
        check("a5_latency", 32'(lat >= 169 && lat <= 171), 32'd1);

        // 0x01, parity 0: odd count of ones, parity_err with frame_valid
        b_valid = n_valid; b_perr = n_perr;
        send_frame(8'h01, 1'b0, 1'b1);
        wait_clk(2 * CPB);
        check("p01_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        check("p01_frame", 32'(frame), 32'h001);
        check("p01_perr_cnt", 32'(n_perr - b_perr), 32'd1);
        check("p01_perr_alone", 32'(n_perr_alone), 32'd0);

        // 5-cycle glitch: rejected at mid start bit
        b_valid = n_valid; b_perr = n_perr; b_ferr = n_ferr;
        rx = 1'b0;
        wait_clk(5);
        check("glitch_busy_hi", 32'(busy), 32'd1);
        rx = 1'b1;
        wait_clk(10);
        check("glitch_busy_lo", 32'(busy), 32'd0);
        check("glitch_pulses", 32'((n_valid - b_valid) + (n_perr - b_perr) + (n_ferr - b_ferr)),
              32'd0);

        // 0x3C with stop low, line held low 40 bit periods
        b_valid = n_valid; b_ferr = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_clk(39 * CPB);
        check("brk_busy", 32'(busy), 32'd1);
        rx = 1'b1;
        wait_clk(2 * CPB);
        check("brk_ferr_cnt", 32'(n_ferr - b_ferr), 32'd1);
        check("brk_valid_cnt", 32'(n_valid - b_valid), 32'd0);
        check("brk_frame_held", 32'(frame), 32'h001);
        check("brk_busy_lo", 32'(busy), 32'd0);

        b_valid = n_valid; b_perr = n_perr;
        send_frame(8'h55, 1'b0, 1'b1);
        wait_clk(2 * CPB);
        check("f55_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        check("f55_frame", 32'(frame), 32'h055);
        check("f55_perr", 32'(n_perr - b_perr), 32'd0);

        // Back-to-back: 0x00/p0 then 0xFF/p1 (eight ones plus parity 1 trips the even rule)
        b_valid = n_valid; b_perr = n_perr;
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        wait_clk(2 * CPB);
        check("b2b_valid_cnt", 32'(n_valid - b_valid), 32'd2);
        check("b2b_frame0", 32'(frames_seen[b_valid % 8]), 32'h000);
        check("b2b_frame1", 32'(frames_seen[(b_valid + 1) % 8]), 32'h1FF);
        check("b2b_perr_cnt", 32'(n_perr - b_perr), 32'd1);

        // Reset pulse in the middle of data bit 4 of 0x81
        b_valid = n_valid; b_ferr = n_ferr;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        rx = 1'b0;
        wait_clk(CPB / 2);
        rst = 1'b0;
        wait_clk(1);
        check("mid_rst_frame", 32'(frame), 32'h000);
        check("mid_rst_outs", 32'({frame_valid, parity_err, frame_err, busy}), 32'h0);
        rst = 1'b1;
        rx  = 1'b1;
        wait_clk(3 * CPB);
        check("mid_rst_no_valid", 32'(n_valid - b_valid), 32'd0);
        check("mid_rst_no_ferr", 32'(n_ferr - b_ferr), 32'd0);

        b_valid = n_valid; b_perr = n_perr;
        send_frame(8'h81, 1'b0, 1'b1);
        wait_clk(2 * CPB);
        check("f81_valid_cnt", 32'(n_valid - b_valid), 32'd1);
        check("f81_frame", 32'(frame), 32'h081);
        check("f81_perr", 32'(n_perr - b_perr), 32'd0);

        check("pulse_width", 32'(n_long), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
